// File: rtl/variance_pkg.sv
// Shared types and widths for variance_unit.
//   accum_state_t : sample accumulation FSM states
//   comp_state_t  : divide/subtract FSM states
//   QUOT_WIDTH / VAR_WIDTH : quotient and result widths for the default sample width
package variance_pkg;

  localparam int unsigned DATA_WIDTH_DEF = 8;
  localparam int unsigned CNT_WIDTH_DEF  = 16;
  localparam int unsigned QUOT_WIDTH     = 2 * DATA_WIDTH_DEF;
  localparam int unsigned VAR_WIDTH      = 2 * DATA_WIDTH_DEF;

  typedef enum logic {
    A_IDLE,
    A_ACC
  } accum_state_t;

  typedef enum logic [1:0] {
    C_IDLE,
    C_WAIT,
    C_DIV,
    C_SUB
  } comp_state_t;

endpackage

// File: rtl/serial_divider.sv
// Restoring divider producing one quotient bit per cycle.
// The quotient is known to fit in QUOT_W bits, so the upper DIVISOR_W bits of
// the dividend are already a valid partial remainder and only the low QUOT_W
// bits need to be shifted through. The first step is taken on the start cycle.
// Ports:
//   clk, rst  : clock, asynchronous active-high reset
//   start     : one-cycle pulse, dividend/divisor valid
//   dividend  : QUOT_W + DIVISOR_W bits
//   divisor   : DIVISOR_W bits, non-zero
//   done      : one-cycle pulse, quotient is final
//   quotient  : QUOT_W bits, held until the next start
module serial_divider
  import variance_pkg::*;
#(
  parameter int unsigned DIVISOR_W = CNT_WIDTH_DEF,
  parameter int unsigned QUOT_W    = QUOT_WIDTH
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic [QUOT_W+DIVISOR_W-1:0]   dividend,
  input  logic [DIVISOR_W-1:0]          divisor,
  output logic                          done,
  output logic [QUOT_W-1:0]             quotient
);

  localparam int unsigned DIVIDEND_W = QUOT_W + DIVISOR_W;
  localparam int unsigned STEP_W     = $clog2(QUOT_W + 1);

  logic [DIVISOR_W-1:0] rem_q, rem_d;
  logic [QUOT_W-1:0]    quo_q, quo_d;
  logic [STEP_W-1:0]    steps_q, steps_d;
  logic                 done_q, done_d;

  logic [DIVISOR_W-1:0] rem_src_c;
  logic [QUOT_W-1:0]    quo_src_c;
  logic [DIVISOR_W:0]   trial_c;
  logic                 fits_c;
  logic                 active_c;

  // One restoring step: shift the next dividend bit into the remainder.
  always_comb begin
    rem_src_c = start ? dividend[DIVIDEND_W-1 -: DIVISOR_W] : rem_q;
    quo_src_c = start ? dividend[QUOT_W-1:0] : quo_q;
    trial_c   = {rem_src_c, quo_src_c[QUOT_W-1]};
    fits_c    = (trial_c >= {1'b0, divisor});
    active_c  = start || (steps_q != '0);

    rem_d   = rem_q;
    quo_d   = quo_q;
    steps_d = steps_q;
    done_d  = 1'b0;

    if (active_c) begin
      rem_d   = fits_c ? DIVISOR_W'(trial_c - {1'b0, divisor}) : DIVISOR_W'(trial_c);
      quo_d   = {quo_src_c[QUOT_W-2:0], fits_c};
      steps_d = start ? STEP_W'(QUOT_W - 1) : steps_q - STEP_W'(1);
      done_d  = (steps_d == '0);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rem_q   <= '0;
      quo_q   <= '0;
      steps_q <= '0;
      done_q  <= 1'b0;
    end else begin
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      steps_q <= steps_d;
      done_q  <= done_d;
    end
  end

  assign done     = done_q;
  assign quotient = quo_q;

endmodule

// File: rtl/variance_unit.sv
// Per-block variance: floor(sum(x^2) / N) - mean^2, clamped at zero.
// An accumulate stage sums squares of enabled samples; a compute stage pairs
// the block with mean_unit's mean and runs a serial divide then a subtract.
// Ports:
//   clk, rst       : clock, asynchronous active-high reset
//   total_samples  : block size N, sampled on start_data_in
//   data_in, en    : sample stream, en qualifies data_in
//   start_data_in  : block start pulse, samples begin next cycle
//   mean_in        : mean from mean_unit, valid while mean_ready is high
//   mean_ready     : mean_unit ready pulse
//   variance_out   : last result, held
//   ready          : one-cycle pulse, variance_out is new
//   busy           : compute stage occupied
//   overflow       : sticky, a block or a mean was dropped
module variance_unit
  import variance_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = DATA_WIDTH_DEF,
  parameter int unsigned CNT_WIDTH   = CNT_WIDTH_DEF,
  parameter int unsigned SUMSQ_WIDTH = 2 * DATA_WIDTH + CNT_WIDTH
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [CNT_WIDTH-1:0]    total_samples,
  input  logic [DATA_WIDTH-1:0]   data_in,
  input  logic                    start_data_in,
  input  logic                    en,
  input  logic [DATA_WIDTH-1:0]   mean_in,
  input  logic                    mean_ready,
  output logic [2*DATA_WIDTH-1:0] variance_out,
  output logic                    ready,
  output logic                    busy,
  output logic                    overflow
);

  localparam int unsigned SQ_W  = 2 * DATA_WIDTH;
  localparam int unsigned VW    = (DATA_WIDTH == DATA_WIDTH_DEF) ? VAR_WIDTH : SQ_W;
  localparam int unsigned DVD_W = SQ_W + CNT_WIDTH;

  // Accumulate stage
  accum_state_t           a_q, a_d;
  logic [CNT_WIDTH-1:0]   total_q, total_d;
  logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
  logic [SUMSQ_WIDTH-1:0] sumsq_q, sumsq_d;

  // Compute stage
  comp_state_t            c_q, c_d;
  logic [SUMSQ_WIDTH-1:0] dvd_q, dvd_d;
  logic [CNT_WIDTH-1:0]   dvs_q, dvs_d;
  logic [DATA_WIDTH-1:0]  mean_use_q, mean_use_d;

  // Mean hold register
  logic [DATA_WIDTH-1:0]  mean_hold_q, mean_hold_d;
  logic                   mean_full_q, mean_full_d;

  // Outputs
  logic [VW-1:0]          variance_q, variance_d;
  logic                   ready_q, ready_d;
  logic                   busy_q, busy_d;
  logic                   overflow_q, overflow_d;

  logic [SQ_W-1:0]        sq_c;
  logic [SUMSQ_WIDTH-1:0] sumsq_inc_c;
  logic [CNT_WIDTH-1:0]   cnt_inc_c;
  logic                   handoff_c;
  logic                   take_c;
  logic                   mean_avail_c;
  logic [DATA_WIDTH-1:0]  mean_pick_c;
  logic                   consume_c;
  logic                   div_start_c;
  logic                   div_done;
  logic [SQ_W-1:0]        quotient;
  logic [SQ_W-1:0]        msq_c;

  // Accumulate FSM: sum squares of enabled samples until N are counted.
  always_comb begin
    sq_c        = SQ_W'(data_in) * SQ_W'(data_in);
    sumsq_inc_c = sumsq_q + SUMSQ_WIDTH'(sq_c);
    cnt_inc_c   = cnt_q + CNT_WIDTH'(1);

    a_d       = a_q;
    total_d   = total_q;
    cnt_d     = cnt_q;
    sumsq_d   = sumsq_q;
    handoff_c = 1'b0;

    if ((a_q == A_ACC) && en) begin
      cnt_d   = cnt_inc_c;
      sumsq_d = sumsq_inc_c;
      if (cnt_inc_c == total_q) begin
        handoff_c = 1'b1;
        a_d       = A_IDLE;
      end
    end

    // A start overrides the running block, but a block completing on this
    // same cycle has already been handed off above.
    if (start_data_in) begin
      total_d = total_samples;
      cnt_d   = '0;
      sumsq_d = '0;
      a_d     = (total_samples == '0) ? A_IDLE : A_ACC;
    end
  end

  // Compute FSM plus mean hold register and output registers.
  always_comb begin
    mean_avail_c = mean_full_q || mean_ready;
    mean_pick_c  = mean_full_q ? mean_hold_q : mean_in;
    // C_SUB is the final cycle of a result, so a new block may land there.
    take_c       = handoff_c && ((c_q == C_IDLE) || (c_q == C_SUB));
    consume_c    = (c_q == C_WAIT) && mean_avail_c;
    msq_c        = SQ_W'(mean_use_q) * SQ_W'(mean_use_q);

    c_d         = c_q;
    dvd_d       = dvd_q;
    dvs_d       = dvs_q;
    mean_use_d  = mean_use_q;
    mean_hold_d = mean_hold_q;
    mean_full_d = mean_full_q;
    variance_d  = variance_q;
    ready_d     = 1'b0;
    overflow_d  = overflow_q;
    div_start_c = 1'b0;

    case (c_q)
      C_IDLE: begin
        if (take_c) c_d = C_WAIT;
      end
      C_WAIT: begin
        if (mean_avail_c) begin
          mean_use_d  = mean_pick_c;
          div_start_c = 1'b1;
          c_d         = C_DIV;
        end
      end
      C_DIV: begin
        if (div_done) c_d = C_SUB;
      end
      C_SUB: begin
        variance_d = (quotient >= msq_c) ? VW'(quotient - msq_c) : '0;
        ready_d    = 1'b1;
        c_d        = take_c ? C_WAIT : C_IDLE;
      end
      default: c_d = C_IDLE;
    endcase

    if (take_c) begin
      dvd_d = sumsq_inc_c;
      dvs_d = total_q;
    end
    if (handoff_c && !take_c) overflow_d = 1'b1;

    // A mean consumed from the hold register frees it for a same-cycle arrival.
    if (consume_c) begin
      if (mean_full_q) begin
        mean_full_d = mean_ready;
        if (mean_ready) mean_hold_d = mean_in;
      end
    end else if (mean_ready) begin
      if (mean_full_q) begin
        overflow_d = 1'b1;
      end else begin
        mean_full_d = 1'b1;
        mean_hold_d = mean_in;
      end
    end

    busy_d = (c_d != C_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q         <= A_IDLE;
      total_q     <= '0;
      cnt_q       <= '0;
      sumsq_q     <= '0;
      c_q         <= C_IDLE;
      dvd_q       <= '0;
      dvs_q       <= '0;
      mean_use_q  <= '0;
      mean_hold_q <= '0;
      mean_full_q <= 1'b0;
      variance_q  <= '0;
      ready_q     <= 1'b0;
      busy_q      <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      a_q         <= a_d;
      total_q     <= total_d;
      cnt_q       <= cnt_d;
      sumsq_q     <= sumsq_d;
      c_q         <= c_d;
      dvd_q       <= dvd_d;
      dvs_q       <= dvs_d;
      mean_use_q  <= mean_use_d;
      mean_hold_q <= mean_hold_d;
      mean_full_q <= mean_full_d;
      variance_q  <= variance_d;
      ready_q     <= ready_d;
      busy_q      <= busy_d;
      overflow_q  <= overflow_d;
    end
  end

  serial_divider #(
    .DIVISOR_W (CNT_WIDTH),
    .QUOT_W    (SQ_W)
  ) u_div (
    .clk      (clk),
    .rst      (rst),
    .start    (div_start_c),
    .dividend (DVD_W'(dvd_q)),
    .divisor  (dvs_q),
    .done     (div_done),
    .quotient (quotient)
  );

  assign variance_out = SQ_W'(variance_q);
  assign ready        = ready_q;
  assign busy         = busy_q;
  assign overflow     = overflow_q;

endmodule

// File: doc/variance_unit.md
Name: variance_unit

Overview:
- Sits downstream of mean_unit and observes the same pixel-block sample stream: data_in, start_data_in, en, total_samples.
- Accumulates the sum of squares of enabled samples and captures mean_unit's mean_out on its ready pulse.
- Computes variance = floor(sumsq / total_samples) - mean^2 with a serial divider.
- Emits one variance value per block for the downstream noise-estimation logic.

Parameters:
- DATA_WIDTH, 8, sample and mean width.
- CNT_WIDTH, 16, width of total_samples and the sample counter; maximum block size is 2^CNT_WIDTH-1.
- SUMSQ_WIDTH, 2*DATA_WIDTH+CNT_WIDTH, sum-of-squares accumulator width.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- total_samples  in  CNT_WIDTH  block size; sampled on start_data_in.
- data_in  in  DATA_WIDTH  sample.
- start_data_in  in  1  one-cycle pulse; samples begin the following cycle.
- en  in  1  qualifies data_in this cycle.
- mean_in  in  DATA_WIDTH  mean_unit mean_out.
- mean_ready  in  1  mean_unit ready pulse; mean_in valid this cycle.
- variance_out  out  2*DATA_WIDTH  result; held until the next result.
- ready  out  1  one-cycle pulse; variance_out is new.
- busy  out  1  compute stage occupied.
- overflow  out  1  sticky; a block or mean was dropped.

Behaviour:
- Reset: all outputs 0; both stages idle; mean hold register empty.
- Accumulate stage, states A_IDLE and A_ACC:
  - start_data_in (any state) latches total_samples, clears the counter and sumsq, then enters A_ACC. A sample on the start cycle is not counted.
  - total_samples==0 on start: stay in A_IDLE and ignore the block.
  - In A_ACC, each cycle with en=1: sumsq += data_in*data_in (unsigned) and cnt++. Cycles with en=0 are ignored.
  - When cnt reaches total_samples, hand {sumsq, N} to the compute stage and return to A_IDLE.
  - If the compute stage is busy at handoff, drop the block and set overflow.
  - start_data_in in the same cycle as the last sample: the last sample completes the current block and the new block starts next cycle.
- Mean hold register:
  - Captures mean_in on every mean_ready pulse in any state.
  - If mean_ready arrives while the register is full, keep the old value and set overflow.
- Compute stage, states C_IDLE, C_WAIT, C_DIV, C_SUB:
  - C_IDLE: on handoff, go to C_WAIT; busy=1.
  - C_WAIT: when the mean hold register is full (or mean_ready is high this cycle), consume it and go to C_DIV.
  - C_DIV: restoring division of sumsq by N, one quotient bit per cycle, exactly 2*DATA_WIDTH cycles. The quotient always fits because sumsq/N <= (2^DATA_WIDTH-1)^2.
  - C_SUB: variance_out = q - mean*mean, clamped at 0 if negative. ready=1 for this cycle only; return to C_IDLE with busy=0.
- Latency: ready asserts 2*DATA_WIDTH+1 cycles after the C_WAIT exit edge. For the default DATA_WIDTH this is 17 cycles.
- Minimum back-to-back spacing: 1 gap + start + 16 samples is sustained with no overflow, provided mean_ready arrives within 1 cycle of the last sample.
- Reset mid-operation: both stages abort immediately; no ready pulse is issued.

Decomposition:
- variance_pkg holds:
  - the accum_state_t and comp_state_t enums;
  - the localparams QUOT_WIDTH=2*DATA_WIDTH and VAR_WIDTH=2*DATA_WIDTH.
- Sub-module serial_divider:
  - inputs: start, dividend[SUMSQ_WIDTH], divisor[CNT_WIDTH];
  - outputs: done, quotient[QUOT_WIDTH];
  - restoring, one bit per cycle, active-high asynchronous reset.
  - The compute FSM drives it from C_DIV.

Test Plan:
- N=16, samples 1..16 all enabled, mean_ready with mean_in=8 one cycle after the last sample -> ready once; variance_out = 1496/16 = 93, minus 64 = 29.
- Back-to-back with a 1-cycle gap: N=16, samples 11..26, mean 18 -> variance_out = 363 - 324 = 39. overflow stays 0.
- Constant 6 x16, mean 6 -> variance_out = 0. Then force mean_in=255 on a constant-6 block -> clamp gives variance_out = 0.
- N=16, 32 samples 1..32 with en high only on odd cycles (values 2, 4, ..., 32), mean 17 -> sumsq = 5984, q = 374, variance_out = 374 - 289 = 85.
- Second block completes while the compute stage is still in C_WAIT (mean withheld) -> overflow=1; the first block still produces its result once the mean arrives.
- rst pulsed mid-C_DIV -> ready never fires, variance_out=0, busy=0. The next full block produces the correct result.
